// File: rtl/axi_fifo_pkt.sv
// axi_fifo_pkt: AXI-Stream FIFO with a distributed-RAM store and a two-stage registered
// output. It can hold frames until their tlast beat arrives (packet mode), and it reports a
// registered occupancy count plus almost-full, almost-empty and oversize flags.
//
// Ports:
//   clk, sync_reset          single clock, synchronous active-high reset
//   s_axis_t{valid,data,last,user}, s_axis_tready   input stream
//   m_axis_t{valid,data,last,user}, m_axis_tready   output stream
//   data_count               words accepted and not yet sent (RAM plus both output stages)
//   almost_full/almost_empty registered threshold flags derived from data_count
//   oversize                 one-cycle pulse when a packet overflows the RAM (packet mode)
module axi_fifo_pkt #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned TUSER_WIDTH         = 8,
    parameter int unsigned ADDR_WIDTH          = 8,
    parameter int unsigned ALMOST_FULL_THRESH  = 16,
    parameter int unsigned ALMOST_EMPTY_THRESH = 4,
    parameter int unsigned PACKET_MODE         = 0
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic [ADDR_WIDTH+1:0]   data_count,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    oversize
);
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned WORD_W = 1 + TUSER_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    AF_LEVEL = CNT_W'(ALMOST_FULL_THRESH);
    localparam logic [CNT_W-1:0]    AE_LEVEL = CNT_W'(ALMOST_EMPTY_THRESH);

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] pkt_count;
    logic                full;
    logic                empty;
    logic                wr_en;
    logic                rd_en;
    logic                read_permit;
    logic                cut_through;
    logic [WORD_W-1:0]   rd_word;
    logic                rd_last;
    logic                d0_valid;
    logic                d1_valid;
    logic [WORD_W-1:0]   d0_word;
    logic [WORD_W-1:0]   d1_word;
    logic                d1_load;
    logic                oversize_armed;
    logic                in_hs;
    logic                out_hs;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign s_axis_tready = !full && !sync_reset;
    assign wr_en         = s_axis_tvalid && s_axis_tready;

    // A full RAM with no complete packet inside would never drain: release it cut-through.
    assign cut_through = full && (pkt_count == '0);

    always_comb begin
        read_permit = !empty;
        if (PACKET_MODE != 0) begin
            read_permit = !empty && ((pkt_count != '0) || full);
        end
    end

    assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_last = rd_word[WORD_W-1];

    // d0 advances into d1 whenever d1 is free or being drained this cycle.
    assign d1_load = d0_valid && (m_axis_tready || !d1_valid);
    assign rd_en   = read_permit && !(d0_valid && d1_valid && !m_axis_tready);

    assign m_axis_tvalid = d1_valid;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = d1_word;

    assign in_hs  = wr_en;
    assign out_hs = d1_valid && m_axis_tready;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pkt_count      <= '0;
            d0_valid       <= 1'b0;
            d1_valid       <= 1'b0;
            d0_word        <= '0;
            d1_word        <= '0;
            data_count     <= '0;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
            oversize       <= 1'b0;
            oversize_armed <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({wr_en && s_axis_tlast, rd_en && rd_last})
                2'b10:   pkt_count <= pkt_count + PTR_ONE;
                2'b01:   pkt_count <= pkt_count - PTR_ONE;
                default: ;
            endcase

            if (rd_en) begin
                d0_word  <= rd_word;
                d0_valid <= 1'b1;
            end else if (d1_load) begin
                d0_valid <= 1'b0;
            end

            if (d1_load) begin
                d1_word  <= d0_word;
                d1_valid <= 1'b1;
            end else if (m_axis_tready) begin
                d1_valid <= 1'b0;
            end

            case ({in_hs, out_hs})
                2'b10:   data_count <= data_count + CNT_ONE;
                2'b01:   data_count <= data_count - CNT_ONE;
                default: ;
            endcase

            almost_full  <= (data_count >= AF_LEVEL);
            almost_empty <= (data_count <= AE_LEVEL);

            // Pulse once per oversize packet; re-arm when a packet end leaves the RAM.
            oversize <= 1'b0;
            if ((PACKET_MODE != 0) && cut_through && oversize_armed) begin
                oversize       <= 1'b1;
                oversize_armed <= 1'b0;
            end
            if (rd_en && rd_last) begin
                oversize_armed <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_fifo_pkt.sv
module tb_axi_fifo_pkt;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int AW = 4;
    localparam int CW = AW + 2;
    localparam int WW = 1 + UW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Instance 0: streaming; instance 1: packet mode.
    logic          rst0, s0_valid, s0_last, s0_ready, m0_valid, m0_last, m0_ready;
    logic [DW-1:0] s0_data, m0_data;
    logic [UW-1:0] s0_user, m0_user;
    logic [CW-1:0] cnt0;
    logic          af0, ae0, ov0;
    logic          rst1, s1_valid, s1_last, s1_ready, m1_valid, m1_last, m1_ready;
    logic [DW-1:0] s1_data, m1_data;
    logic [UW-1:0] s1_user, m1_user;
    logic [CW-1:0] cnt1;
    logic          af1, ae1, ov1;

    logic rand_rdy = 1'b0;
    logic rnd_bit  = 1'b0;
    logic rdy0_fix = 1'b0;
    assign m0_ready = rand_rdy ? rnd_bit : rdy0_fix;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    logic [WW-1:0] q0[$];
    logic [WW-1:0] q1[$];

    axi_fifo_pkt #(
        .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_THRESH(16), .ALMOST_EMPTY_THRESH(4), .PACKET_MODE(0)
    ) u_str (
        .clk(clk), .sync_reset(rst0),
        .s_axis_tvalid(s0_valid), .s_axis_tdata(s0_data), .s_axis_tlast(s0_last),
        .s_axis_tuser(s0_user), .s_axis_tready(s0_ready),
        .m_axis_tvalid(m0_valid), .m_axis_tdata(m0_data), .m_axis_tlast(m0_last),
        .m_axis_tuser(m0_user), .m_axis_tready(m0_ready),
        .data_count(cnt0), .almost_full(af0), .almost_empty(ae0), .oversize(ov0)
    );

    axi_fifo_pkt #(
        .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_THRESH(16), .ALMOST_EMPTY_THRESH(4), .PACKET_MODE(1)
    ) u_pkt (
        .clk(clk), .sync_reset(rst1),
        .s_axis_tvalid(s1_valid), .s_axis_tdata(s1_data), .s_axis_tlast(s1_last),
        .s_axis_tuser(s1_user), .s_axis_tready(s1_ready),
        .m_axis_tvalid(m1_valid), .m_axis_tdata(m1_data), .m_axis_tlast(m1_last),
        .m_axis_tuser(m1_user), .m_axis_tready(m1_ready),
        .data_count(cnt1), .almost_full(af1), .almost_empty(ae1), .oversize(ov1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
    endtask

    // Monitors: scoreboard pop on output handshakes, and a running occupancy model.
    int model0 = 0, prev0 = 0, model1 = 0, prev1 = 0;
    bit started0 = 1'b0, started1 = 1'b0;
    int ov_pulses = 0;

    always @(negedge clk) begin
        logic [WW-1:0] exp_w;
        if (started0 && !rst0) begin
            check("af0", 64'(af0), 64'(prev0 >= 16));
            check("ae0", 64'(ae0), 64'(prev0 <= 4));
            check("count0", 64'(cnt0), 64'(model0));
            check("ov0", 64'(ov0), 64'(0));
            if (m0_valid && m0_ready) begin
                if (q0.size() == 0) begin
                    timeout("beat0_unexpected");
                end else begin
                    exp_w = q0.pop_front();
                    check("beat0", 64'({m0_last, m0_user, m0_data}), 64'(exp_w));
                end
            end
        end
        prev0 = model0;
        if (rst0) begin
            model0 = 0; prev0 = 0; started0 = 1'b1;
        end else begin
            model0 += int'(s0_valid && s0_ready) - int'(m0_valid && m0_ready);
        end
    end

    always @(negedge clk) begin
        logic [WW-1:0] exp_w;
        if (ov1 === 1'b1) ov_pulses++;
        if (started1 && !rst1) begin
            check("af1", 64'(af1), 64'(prev1 >= 16));
            check("ae1", 64'(ae1), 64'(prev1 <= 4));
            check("count1", 64'(cnt1), 64'(model1));
            if (m1_valid && m1_ready) begin
                if (q1.size() == 0) begin
                    timeout("beat1_unexpected");
                end else begin
                    exp_w = q1.pop_front();
                    check("beat1", 64'({m1_last, m1_user, m1_data}), 64'(exp_w));
                end
            end
        end
        prev1 = model1;
        if (rst1) begin
            model1 = 0; prev1 = 0; started1 = 1'b1;
        end else begin
            model1 += int'(s1_valid && s1_ready) - int'(m1_valid && m1_ready);
        end
    end

    // Drivers: called at posedge+1, return at posedge+1 of the cycle after the handshake.
    task automatic push0(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
        s0_valid = 1'b1; s0_data = d; s0_user = u; s0_last = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s0_ready) begin
                q0.push_back({l, u, d});
                @(posedge clk); #1;
                s0_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        timeout("push0");
        s0_valid = 1'b0;
    endtask

    task automatic push1(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
        s1_valid = 1'b1; s1_data = d; s1_user = u; s1_last = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s1_ready) begin
                q1.push_back({l, u, d});
                @(posedge clk); #1;
                s1_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        timeout("push1");
        s1_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int which);
        for (int t = 0; t < 30000; t++) begin
            if (((which == 0) ? q0.size() : q1.size()) == 0) return;
            @(negedge clk);
        end
        timeout(name);
    endtask

    initial begin
        int n;
        rst0 = 1'b1; rst1 = 1'b1;
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0; s0_user = '0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; s1_user = '0;
        m1_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready0", 64'(s0_ready), 64'(0));
        check("rst_tready1", 64'(s1_ready), 64'(0));
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(m0_valid), 64'(0));
        check("rst_tdata", 64'(m0_data), 64'(0));
        check("rst_tlast", 64'(m0_last), 64'(0));
        check("rst_tuser", 64'(m0_user), 64'(0));
        check("rst_count", 64'(cnt0), 64'(0));
        check("rst_af", 64'(af0), 64'(0));
        check("rst_ae", 64'(ae0), 64'(1));
        check("rst_ov", 64'(ov1), 64'(0));
        check("post_rst_tready", 64'(s0_ready), 64'(1));
        @(posedge clk); #1;

        // Fill: 16 RAM words plus 2 output stages.
        for (int i = 0; i < 18; i++) push0(32'(i), 8'(i), 1'b0);
        @(negedge clk);
        check("full_tready", 64'(s0_ready), 64'(0));
        check("full_count", 64'(cnt0), 64'(18));
        @(negedge clk);
        check("full_af", 64'(af0), 64'(1));
        @(posedge clk); #1;
        rdy0_fix = 1'b1;
        drain("drain_fill", 0);
        repeat (3) @(negedge clk);
        check("drained_count", 64'(cnt0), 64'(0));
        check("drained_ae", 64'(ae0), 64'(1));
        @(posedge clk); #1;

        // Streaming latency.
        push0(32'hA5, 8'h00, 1'b0);
        n = 1;
        @(negedge clk);
        while (!m0_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("latency", 64'(n), 64'(3));
        check("latency_data", 64'(m0_data), 64'(32'hA5));
        @(posedge clk); #1;

        // Random valid/ready with random tuser/tlast.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
            push0($urandom, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain("drain_rand", 0);
        rand_rdy = 1'b0;
        @(posedge clk); #2;

        // Packet mode: 5 beats with 2 idle cycles between them.
        m1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push1(32'h200 + 32'(i), 8'h10 + 8'(i), i == 4);
            if (i < 4) begin
                repeat (2) begin
                    @(negedge clk);
                    check("pkt_hold", 64'(m1_valid), 64'(0));
                    @(posedge clk); #1;
                end
            end
        end
        n = 1;
        @(negedge clk);
        while (!m1_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("pkt_latency", 64'(n), 64'(3));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("pkt_burst_valid", 64'(m1_valid), 64'(1));
            check("pkt_burst_last", 64'(m1_last), 64'(k == 4));
        end
        drain("drain_pkt", 1);
        @(posedge clk); #1;

        // Oversize: 20-beat packet into a 16-word RAM.
        ov_pulses = 0;
        for (int i = 0; i < 20; i++) push1(32'h100 + 32'(i), 8'(i), i == 19);
        drain("drain_ovs", 1);
        repeat (4) @(negedge clk);
        check("ovs_pulses", 64'(ov_pulses), 64'(1));
        @(posedge clk); #1;

        // Reset with 7 words of an unfinished packet buffered.
        m1_ready = 1'b0;
        for (int i = 0; i < 7; i++) push1(32'h300 + 32'(i), 8'h33, 1'b0);
        @(negedge clk);
        check("mid_count", 64'(cnt1), 64'(7));
        @(posedge clk); #1;
        rst1 = 1'b1;
        q1.delete();
        @(negedge clk);
        check("mid_rst_tready", 64'(s1_ready), 64'(0));
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(negedge clk);
        check("mid_rst_tvalid", 64'(m1_valid), 64'(0));
        check("mid_rst_count", 64'(cnt1), 64'(0));
        @(posedge clk); #1;
        m1_ready = 1'b1;
        for (int i = 0; i < 3; i++) push1(32'h400 + 32'(i), 8'h44, i == 2);
        drain("drain_post_rst", 1);
        repeat (10) @(negedge clk);
        check("post_rst_count", 64'(cnt1), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
